// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode/issue: each word is fully decoded
// on entry and held with its PC and delay-slot tag until the consumer takes it.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_ctrl,
  output logic            out_memen,
  output logic            out_jal,
  output logic            out_jr,
  output logic            out_bal,
  output logic            out_wr31,
  output logic            out_hlwrite,
  output logic            out_cp0we,
  output logic            out_cp0read,
  output logic            out_eret,
  output logic            out_syscall,
  output logic            out_break,
  output logic            out_ri,
  output logic            out_is_ds
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ctrl = {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump}
  typedef struct packed {
    logic [6:0] ctrl;
    logic       memen;
    logic       jal;
    logic       jr;
    logic       bal;
    logic       wr31;
    logic       hlwrite;
    logic       cp0we;
    logic       cp0read;
    logic       eret;
    logic       syscall;
    logic       brk;
    logic       ri;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    d     = '0;
    op    = instr[31:26];
    rt    = instr[20:16];
    funct = instr[5:0];
    case (op)
      6'h00: begin
        case (funct)
          6'h08: begin d.ctrl = 7'b0000001; d.jr = 1'b1; end
          6'h09: begin d.ctrl = 7'b1100000; d.jr = 1'b1; end
          6'h0C: d.syscall = 1'b1;
          6'h0D: d.brk = 1'b1;
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
            d.ctrl    = 7'b1100000;
            d.hlwrite = 1'b1;
          end
          default: d.ctrl = 7'b1100000;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: d.ctrl = 7'b0001000;
          5'h10, 5'h11: begin
            d.ctrl = 7'b1001000;
            d.bal  = 1'b1;
            d.wr31 = 1'b1;
          end
          default: d.ri = 1'b1;
        endcase
      end
      6'h02: d.ctrl = 7'b0000001;
      6'h03: begin d.ctrl = 7'b1000000; d.jal = 1'b1; d.wr31 = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: d.ctrl = 7'b0001000;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: d.ctrl = 7'b1010000;
      6'h10: begin
        if (instr[31:21] == 11'h204 && instr[10:0] == 11'h000)
          d.cp0we = 1'b1;
        else if (instr[31:21] == 11'h200 && instr[10:0] == 11'h000)
          d.cp0read = 1'b1;
        else if (instr == 32'h4200_0018)
          d.eret = 1'b1;
        else
          d.ri = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d.ctrl  = 7'b1010010;
        d.memen = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        d.ctrl  = 7'b0010100;
        d.memen = 1'b1;
      end
      default: d.ri = 1'b1;
    endcase
    return d;
  endfunction

  // Anything that owns a delay slot: branch, jump, jal, jr, bal.
  function automatic logic has_slot(input dec_t d);
    return d.ctrl[3] | d.ctrl[0] | d.jal | d.jr | d.bal;
  endfunction

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  dec_t            dec_mem   [DEPTH];
  logic            ds_mem    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ds_pending;
  logic          push;
  logic          pop;
  dec_t          dec_in;
  dec_t          head;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign dec_in    = decode(in_instr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        ds_pending <= has_slot(dec_in);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: data only, validity is carried by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
      dec_mem[wr_ptr]   <= dec_in;
      ds_mem[wr_ptr]    <= ds_pending;
    end
  end

  assign head        = out_valid ? dec_mem[rd_ptr] : '0;
  assign out_instr   = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc      = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_is_ds   = out_valid & ds_mem[rd_ptr];
  assign out_ctrl    = head.ctrl;
  assign out_memen   = head.memen;
  assign out_jal     = head.jal;
  assign out_jr      = head.jr;
  assign out_bal     = head.bal;
  assign out_wr31    = head.wr31;
  assign out_hlwrite = head.hlwrite;
  assign out_cp0we   = head.cp0we;
  assign out_cp0read = head.cp0read;
  assign out_eret    = head.eret;
  assign out_syscall = head.syscall;
  assign out_break   = head.brk;
  assign out_ri      = head.ri;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vector table, handshake/ordering scoreboard,
// and hand-written delay-slot, flush and reset sequences.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  localparam logic [11:0] F_MEMEN = 12'h800, F_JAL  = 12'h400, F_JR   = 12'h200,
                          F_BAL   = 12'h100, F_WR31 = 12'h080, F_HL   = 12'h040,
                          F_CPWE  = 12'h020, F_CPRD = 12'h010, F_ERET = 12'h008,
                          F_SYS   = 12'h004, F_BRK  = 12'h002, F_RI   = 12'h001;

  logic            clk = 1'b0;
  logic            resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [6:0]      out_ctrl;
  logic out_memen, out_jal, out_jr, out_bal, out_wr31, out_hlwrite;
  logic out_cp0we, out_cp0read, out_eret, out_syscall, out_break, out_ri, out_is_ds;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_memen(out_memen), .out_jal(out_jal), .out_jr(out_jr),
    .out_bal(out_bal), .out_wr31(out_wr31), .out_hlwrite(out_hlwrite),
    .out_cp0we(out_cp0we), .out_cp0read(out_cp0read), .out_eret(out_eret),
    .out_syscall(out_syscall), .out_break(out_break), .out_ri(out_ri),
    .out_is_ds(out_is_ds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  ctrl;
    logic [11:0] flags;
  } vec_t;

  vec_t        vecs [21];
  logic [63:0] sb [$];
  int          npass = 0;
  int          ntot  = 0;

  function automatic logic [11:0] flags_now();
    return {out_memen, out_jal, out_jr, out_bal, out_wr31, out_hlwrite,
            out_cp0we, out_cp0read, out_eret, out_syscall, out_break, out_ri};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else npass++;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [6:0] ctrl,
                            input logic [11:0] flags, input logic ds);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_ctrl"},  32'(out_ctrl),  32'(ctrl));
    check({name, "_flags"}, 32'(flags_now()), 32'(flags));
    check({name, "_ds"},    32'(out_is_ds), 32'(ds));
  endtask

  task automatic sb_compare(input string name);
    logic [63:0] e;
    if (sb.size() == 0) begin
      check({name, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_instr"}, out_instr, e[63:32]);
      check({name, "_pc"},    out_pc,    e[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    vecs[0]  = '{32'h2401_0005, 7'b1010000, 12'h000};           // ADDIU
    vecs[1]  = '{32'h1000_0003, 7'b0001000, 12'h000};           // BEQ
    vecs[2]  = '{32'h8C22_0000, 7'b1010010, F_MEMEN};           // LW
    vecs[3]  = '{32'hAC22_0000, 7'b0010100, F_MEMEN};           // SW
    vecs[4]  = '{32'h0800_0000, 7'b0000001, 12'h000};           // J
    vecs[5]  = '{32'h0C00_0000, 7'b1000000, F_JAL | F_WR31};    // JAL
    vecs[6]  = '{32'h03E0_0008, 7'b0000001, F_JR};              // JR
    vecs[7]  = '{32'h0040_F809, 7'b1100000, F_JR};              // JALR
    vecs[8]  = '{32'h0000_000C, 7'b0000000, F_SYS};             // SYSCALL
    vecs[9]  = '{32'h0000_000D, 7'b0000000, F_BRK};             // BREAK
    vecs[10] = '{32'h0043_0018, 7'b1100000, F_HL};              // MULT
    vecs[11] = '{32'h0043_1021, 7'b1100000, 12'h000};           // ADDU
    vecs[12] = '{32'h0411_0002, 7'b1001000, F_BAL | F_WR31};    // BGEZAL
    vecs[13] = '{32'h0400_0002, 7'b0001000, 12'h000};           // BLTZ
    vecs[14] = '{32'h0405_0000, 7'b0000000, F_RI};              // REGIMM rt=5
    vecs[15] = '{32'h4082_6000, 7'b0000000, F_CPWE};            // MTC0
    vecs[16] = '{32'h4002_6000, 7'b0000000, F_CPRD};            // MFC0
    vecs[17] = '{32'h4200_0018, 7'b0000000, F_ERET};            // ERET
    vecs[18] = '{32'h4082_6001, 7'b0000000, F_RI};              // COP0 bad low bits
    vecs[19] = '{32'hFC00_0000, 7'b0000000, F_RI};              // undefined op
    vecs[20] = '{32'h3C01_0001, 7'b1010000, 12'h000};           // LUI

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_ctrl",      32'(out_ctrl),  32'd0);
    check("rst_flags",     32'(flags_now()), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      do_flush();
      push_one(vecs[i].instr, 32'h400 + 32'(i) * 4);
      check_head($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].flags, 1'b0);
      check($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
      pop_one();
      check($sformatf("vec%0d_empty", i), 32'(out_valid), 32'd0);
    end

    // Branch followed by load: the load is tagged as a delay slot.
    do_flush();
    push_one(32'h1000_0003, 32'h100);
    push_one(32'h8C22_0000, 32'h104);
    check_head("beq", 7'b0001000, 12'h000, 1'b0);
    pop_one();
    check_head("lw_ds", 7'b1010010, F_MEMEN, 1'b1);
    check("lw_ds_pc", out_pc, 32'h104);
    pop_one();

    // System/CP0 sequence; the MTC0 sits in BGEZAL's slot.
    do_flush();
    push_one(32'h0000_000C, 32'h200);
    push_one(32'h4200_0018, 32'h204);
    push_one(32'h0411_0002, 32'h208);
    push_one(32'h4082_6000, 32'h20C);
    check("seq_full", 32'(in_ready), 32'd0);
    check_head("seq_sys", 7'b0000000, F_SYS, 1'b0);
    pop_one();
    check_head("seq_eret", 7'b0000000, F_ERET, 1'b0);
    pop_one();
    check_head("seq_bal", 7'b1001000, F_BAL | F_WR31, 1'b0);
    pop_one();
    check_head("seq_cp0we", 7'b0000000, F_CPWE, 1'b1);
    pop_one();
    check("seq_empty", 32'(out_valid), 32'd0);

    // Fill, rejected push while full, then random streaming across wraps.
    do_flush();
    sb.delete();
    idx = 0;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("fill%0d_ready", k), 32'(in_ready), 32'd1);
      sb.push_back({32'h2401_0000 | 32'(idx), 32'h1000 + 32'(idx) * 4});
      push_one(32'h2401_0000 | 32'(idx), 32'h1000 + 32'(idx) * 4);
      idx++;
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_one(32'h2401_00FF, 32'hDEAD);
    check("full_reject_ready", 32'(in_ready), 32'd0);
    sb_compare("full_pop");
    pop_one();
    check("after_pop_ready", 32'(in_ready), 32'd1);

    for (int c = 0; c < 40; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = 32'h2401_0000 | 32'(idx);
      in_pc     = 32'h1000 + 32'(idx) * 4;
      if (out_valid && out_ready) sb_compare($sformatf("stream%0d", c));
      if (in_valid && in_ready) begin
        sb.push_back({in_instr, in_pc});
        idx++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_valid; c++) begin
      sb_compare($sformatf("drain%0d", c));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_done", 32'(out_valid), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with a pending branch and a simultaneous push.
    do_flush();
    push_one(32'h2401_0001, 32'h300);
    push_one(32'h2401_0002, 32'h304);
    push_one(32'h1000_0003, 32'h308);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h8C22_0000; in_pc = 32'h30C;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    push_one(32'h2401_0003, 32'h310);
    check_head("post_flush", 7'b1010000, 12'h000, 1'b0);
    check("post_flush_instr", out_instr, 32'h2401_0003);
    pop_one();

    // Asynchronous reset mid-stream.
    push_one(32'h2401_0004, 32'h400);
    push_one(32'h2401_0005, 32'h404);
    resetn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_instr",     out_instr,      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("arst_after", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised, registered successor to the combinational main decoder: a DEPTH-entry instruction queue between fetch and the decode/issue stage. Each instruction is fully decoded when enqueued, covering main control, jump-link, HI/LO write, CP0 and trap flags. Decoded bundles are held with PC and delay-slot tag and released under a valid/ready handshake. Adds back-pressure, flush, reserved-instruction detection and delay-slot tracking, none of which a bare decoder has.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- PC_W, 32: PC width.
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (exception/branch redirect).
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode stage consumes head.
- out_instr  out  32; out_pc  out  PC_W  head instruction and PC.
- out_ctrl  out  7  {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump}.
- out_memen, out_jal, out_jr, out_bal, out_wr31, out_hlwrite  out  1 each.
- out_cp0we, out_cp0read, out_eret, out_syscall, out_break, out_ri  out  1 each (ri = reserved instruction).
- out_is_ds  out  1  head sits in a branch delay slot.

## Operation
- Push when in_valid&&in_ready; pop when out_valid&&out_ready. in_ready = (count<DEPTH), registered-state only, no path from out_ready; full queue does not accept even when popping that cycle.
- Circular buffer, read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- Decode at push (op=instr[31:26], rt=[20:16], funct=[5:0]); stored per entry:
  - op 0x00: funct JR 0x08 → ctrl 0000001, jr; JALR 0x09 → 1100000, jr; SYSCALL 0x0C → syscall, ctrl 0; BREAK 0x0D → break, ctrl 0; MTHI/MTLO/MULT/MULTU/DIV/DIVU (0x11,0x13,0x18,0x19,0x1A,0x1B) → hlwrite, ctrl 1100000; other funct → 1100000.
  - ANDI,ORI,XORI,LUI,ADDI,ADDIU,SLTI,SLTIU → 1010000.
  - BEQ,BNE,BLEZ,BGTZ → 0001000. J → 0000001. JAL → 1000000, jal, wr31.
  - REGIMM 0x01: rt BLTZ 0x00/BGEZ 0x01 → 0001000; BLTZAL 0x10/BGEZAL 0x11 → 1001000, bal, wr31; other rt → ri.
  - LB,LH,LW,LBU,LHU → 1010010, memen. SB,SH,SW → 0010100, memen.
  - COP0 0x10: instr[31:21]=0x204 & [10:0]=0 → cp0we; [31:21]=0x200 & [10:0]=0 → cp0read; instr=0x42000018 → eret; other → ri.
  - Any other op → ri, ctrl 0.
- Delay slot: ds_pending set when a pushed entry has branch|jump|jal|jr|bal; next pushed entry gets is_ds=1 and clears ds_pending.
- All out_* except out_valid forced 0 when out_valid=0.
- flush: count, pointers, ds_pending cleared; overrides any push/pop that cycle.

## Timing
- Reset (resetn low, async): count=0, pointers 0, ds_pending=0 → out_valid=0, all outputs 0, in_ready=1.
- Latency: instruction pushed at edge n is at head, out_valid=1, from n+1 (empty queue).
- Throughput: 1 push + 1 pop per cycle when 0<count<DEPTH; count unchanged.
- Full: in_ready=0; pop at edge n → in_ready=1 after n.
- Empty: pop suppressed; only push affects count.
- Flush and in_valid same cycle: instruction dropped; out_valid=0 next cycle.
- resetn deasserted mid-stream: contents lost, same as reset state.

## Test plan
- Reset then push 0x24010005 (ADDIU): next cycle out_valid=1, out_ctrl=1010000, out_ri=0, out_is_ds=0.
- Push 0x10000003 (BEQ) then 0x8C220000 (LW): second head has out_is_ds=1, out_ctrl=1010010, out_memen=1; BEQ ctrl=0001000.
- out_ready=0, push DEPTH instrs: in_ready=0 after DEPTH-th push; a further in_valid is not accepted; one pop → in_ready=1 next cycle; FIFO order preserved across pointer wrap (≥2·DEPTH instrs).
- Push 0x0000000C, 0x42000018, 0x04110002, 0x40826000: syscall=1; eret=1; bal=1,wr31=1,ctrl=1001000; cp0we=1.
- Push 0xFC000000 and 0x04050000: out_ri=1, ctrl=0 for both.
- 3 entries queued plus flush with in_valid=1: next cycle out_valid=0, in_ready=1; subsequent push after a pending branch gets is_ds=0.
